// File: rtl/branch_predict_unit.sv
// RV32 B-type branch resolution with a PC-indexed table of 2-bit saturating counters.
// Optional macro BRANCH_PREDICT_STATS_EN adds branch/mispredict statistics counters.
module branch_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IDX_W     = 6,
  parameter logic [1:0]  RESET_CTR = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_b_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_opr_a,
  input  logic [XLEN-1:0] ex_opr_b,
  input  logic            ex_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            res_illegal
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned DEPTH  = 2 ** IDX_W;
  localparam int unsigned CTR_W  = 2;
  localparam int unsigned STAT_W = 32;

  logic [CTR_W-1:0] ctr_q [DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_nxt;
  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic             cond;
  logic             illegal;
  logic             upd;
  logic             mispredict_d;
  logic             unused_pc_bits;

  // Word-aligned PCs; bits above the index alias onto the same entry.
  assign pred_idx = pred_pc[IDX_W+1:2];
  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // Fetch sees the stored counter; no bypass from a same-cycle update.
  assign pred_taken = ctr_q[pred_idx][CTR_W-1];

  assign eq   = (ex_opr_a == ex_opr_b);
  assign lt_s = ($signed(ex_opr_a) < $signed(ex_opr_b));
  assign lt_u = (ex_opr_a < ex_opr_b);

  // Branch condition decode.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (ex_funct3)
      3'b000:         cond = eq;
      3'b001:         cond = ~eq;
      3'b100:         cond = lt_s;
      3'b101:         cond = ~lt_s;
      3'b110:         cond = lt_u;
      3'b111:         cond = ~lt_u;
      3'b010, 3'b011: illegal = 1'b1;
      default:        cond = 1'b0;
    endcase
  end

  assign upd          = ex_valid & ex_is_b_type;
  assign mispredict_d = upd & ~illegal & (cond != ex_pred_taken);

  // Saturating counter step for the execute-stage entry.
  always_comb begin
    ctr_cur = ctr_q[ex_idx];
    ctr_nxt = ctr_cur;
    if (cond) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= RESET_CTR;
    end else if (upd && !illegal) begin
      ctr_q[ex_idx] <= ctr_nxt;
    end
  end

  // Resolution results live for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      res_illegal    <= 1'b0;
    end else begin
      res_valid      <= upd;
      res_taken      <= upd & cond;
      res_mispredict <= mispredict_d;
      res_illegal    <= upd & illegal;
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  // Clear wins over increment; both counters wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd)          stat_branches    <= stat_branches + STAT_W'(1);
      if (mispredict_d) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`endif

endmodule
